ps2_tx: RTL and testbench
=========================

# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, enable 0xF4) from the host to a PS/2 keyboard or mouse. It drives the shared open-drain clock and data lines through active-high pull-low enables. It samples the device-generated clock with the same 5-sample edge detector as the PS/2 receiver. It sits beside the receiver on the same pins; the top level blocks receiver `rdy` while `busy` is high.

## Interface
- `FREQ`, 50000, main clock frequency in KHz; must be ≤ 69900 so every count fits the 20-bit timer.
- `INHIBIT`, FREQ/10, cycles the clock line is held low before the request (100 µs).
- `SETUP`, FREQ/200, cycles data and clock are both held low before the clock is released (5 µs).
- `START_TIMEOUT`, FREQ*15, max cycles from clock release to the first device falling edge (15 ms).
- `BIT_TIMEOUT`, FREQ*2, max cycles between consecutive device clock edges (2 ms).
- `clk`  in  1  main clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  PS/2 clock pin level (asynchronous).
- `ps2_data`  in  1  PS/2 data pin level (asynchronous).
- `din`  in  8  byte to send; captured when `wr` is accepted.
- `wr`  in  1  write strobe; accepted only when `busy`=0.
- `ps2_clk_oe`  out  1  1 = pull PS/2 clock low.
- `ps2_data_oe`  out  1  1 = pull PS/2 data low.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: byte sent and acknowledged.
- `error`  out  1  one-cycle pulse: timeout or missing ack.

## Operation
- Edge detect: 5-bit shift `s` of `ps2_clk`, reset to 5'b11111. Falling edge when s[4:1]==4'b1100, rising edge when s[4:1]==4'b0011. `ps2_data` goes through two flops before use.
- On accept: shift register `sh[9:0]` = {1'b1 stop, ~^din odd parity, din}; bit counter `n`=0; timer=0.
- IDLE: both OEs 0. `wr` → INHIBIT.
- INHIBIT: clk_oe=1. When timer==INHIBIT-1 → SETUP; timer cleared.
- SETUP: clk_oe=1, data_oe=1 (start bit). When timer==SETUP-1 → BITS; clk_oe drops to 0; timer cleared.
- BITS: on each falling edge, data_oe = ~sh[0], shift sh right, n++. Edges 1–8 send data LSB first, edge 9 sends parity, edge 10 sends stop (data_oe=0). After edge 10 → ACK.
- ACK: on the 11th falling edge, sample synced data. Data=0 (ack) → WAIT_IDLE. Data=1 → error pulse, then IDLE.
- WAIT_IDLE: when s[1]==1 and synced data==1 → DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Timer: 20-bit; cleared on state entry and on any edge, saturates at its maximum.
- Timeouts: in BITS with n==0, timer==START_TIMEOUT fails. Elsewhere in BITS, ACK or WAIT_IDLE, timer==BIT_TIMEOUT fails. On failure: `error` pulses one cycle, both OEs drop to 0 in that same cycle, and the next state is IDLE.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, state IDLE, s=5'b11111.
- Every output is registered.
- `wr` at cycle 0 → busy=1 and clk_oe=1 at cycle 1. data_oe=1 at cycle 1+INHIBIT. clk_oe=0 at cycle 1+INHIBIT+SETUP.
- A data change happens 1 cycle after the falling edge is detected, which is 4 samples after the pin edge.
- `wr` while busy, including the DONE cycle, is ignored; `din` is not re-captured.
- `done` and `error` are never high together.
- Reset mid-transfer: both OEs are 0 on the next clock edge; no done/error pulse.
- Rising edges only restart the timer; they do not shift data.

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined: ACK state behaves as above; ack=1 gives an `error` pulse.
- Not defined: the ack sample is ignored; the 11th falling edge always goes to WAIT_IDLE and ends in `done`. Timeouts still give `error`.

## Test plan
- Send 0xF4 with a device model clocking at 12.5 KHz and driving ack. On edges 1–10, `ps2_data` (as the device sees it) reads 0,0,1,0,1,1,1,1, parity 0, stop 1. `done` pulses once; `error` stays 0.
- Send 0xED. Parity bit 1 is seen on edge 9. Clock is held low ≥ INHIBIT cycles, and data goes low before the clock is released.
- Device never clocks after release. `error` pulses at START_TIMEOUT cycles after release; both OEs are 0 in that cycle.
- Device stops after edge 5. `error` pulses BIT_TIMEOUT cycles after the last edge; busy=0 on the next cycle.
- Device omits the ack (data=1 on edge 11). With the macro: `error`. Without it: `done`.
- Second `wr` (din=0xAA) mid-transfer is ignored, so 0xF4 is still sent. Reset asserted at edge 4 releases both lines next cycle, with no done/error pulse.

Source files
------------

// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Purpose  : Host-to-device PS/2 byte transmitter driving open-drain pull-low
//            enables. Optional macro PS2_TX_ACK_CHECK_EN enables ack checking.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tx #(
  parameter int FREQ          = 50000,
  parameter int INHIBIT       = FREQ / 10,
  parameter int SETUP         = FREQ / 200,
  parameter int START_TIMEOUT = FREQ * 15,
  parameter int BIT_TIMEOUT   = FREQ * 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_inhibit   = 3'd1;
  localparam logic [2:0] c_st_setup     = 3'd2;
  localparam logic [2:0] c_st_bits      = 3'd3;
  localparam logic [2:0] c_st_ack       = 3'd4;
  localparam logic [2:0] c_st_wait_idle = 3'd5;
  localparam logic [2:0] c_st_done      = 3'd6;

  localparam logic [19:0] c_inhibit_last = 20'(INHIBIT - 1);
  localparam logic [19:0] c_setup_last   = 20'(SETUP - 1);
  localparam logic [19:0] c_start_limit  = 20'(START_TIMEOUT);
  localparam logic [19:0] c_bit_limit    = 20'(BIT_TIMEOUT);
  localparam logic [19:0] c_timer_max    = 20'hF_FFFF;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [4:0]  r_s;
  logic        r_d_meta;
  logic        r_d_sync;
  logic [9:0]  r_sh;
  logic [3:0]  r_n;
  logic [19:0] r_timer;
  logic        r_clk_oe;
  logic        r_data_oe;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_fall;
  logic        w_rise;
  logic        w_timeout;
  logic        w_fail;
  logic        w_edge_live;
  logic        w_clk_oe_next;
  logic        w_data_oe_next;
  logic        w_busy_next;
  logic        w_done_next;

  assign w_fall = (r_s[4:1] == 4'b1100);
  assign w_rise = (r_s[4:1] == 4'b0011);

  // Before the first device edge the long start window applies.
  assign w_timeout = ((r_state == c_st_bits) && (r_n == 4'd0)) ?
                     (r_timer == c_start_limit) : (r_timer == c_bit_limit);

  // Our own clock pull during INHIBIT/SETUP must not disturb the timer.
  assign w_edge_live = ((r_state == c_st_bits) || (r_state == c_st_ack) ||
                        (r_state == c_st_wait_idle)) && (w_fall || w_rise);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_fail       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (wr) w_state_next = c_st_inhibit;
      end
      c_st_inhibit: begin
        if (r_timer == c_inhibit_last) w_state_next = c_st_setup;
      end
      c_st_setup: begin
        if (r_timer == c_setup_last) w_state_next = c_st_bits;
      end
      c_st_bits: begin
        if (w_timeout) begin
          w_fail       = 1'b1;
          w_state_next = c_st_idle;
        end else if (w_fall && (r_n == 4'd9)) begin
          w_state_next = c_st_ack;
        end
      end
      c_st_ack: begin
        if (w_timeout) begin
          w_fail       = 1'b1;
          w_state_next = c_st_idle;
        end else if (w_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
          if (r_d_sync) begin
            w_fail       = 1'b1;
            w_state_next = c_st_idle;
          end else begin
            w_state_next = c_st_wait_idle;
          end
`else
          w_state_next = c_st_wait_idle;
`endif
        end
      end
      c_st_wait_idle: begin
        if (w_timeout) begin
          w_fail       = 1'b1;
          w_state_next = c_st_idle;
        end else if (r_s[1] && r_d_sync) begin
          w_state_next = c_st_done;
        end
      end
      c_st_done: begin
        w_state_next = c_st_idle;
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_clk_oe_next  = (w_state_next == c_st_inhibit) || (w_state_next == c_st_setup);
    w_busy_next    = (w_state_next != c_st_idle);
    w_done_next    = (w_state_next == c_st_done);
    w_data_oe_next = 1'b0;
    if (w_state_next == c_st_setup) begin
      w_data_oe_next = 1'b1;
    end else if (w_state_next == c_st_bits) begin
      w_data_oe_next = ((r_state == c_st_bits) && w_fall) ? ~r_sh[0] : r_data_oe;
    end
  end

  // Synchronisers, shifter, bit counter, timer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s       <= 5'b11111;
      r_d_meta  <= 1'b1;
      r_d_sync  <= 1'b1;
      r_sh      <= 10'd0;
      r_n       <= 4'd0;
      r_timer   <= 20'd0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_s      <= {r_s[3:0], ps2_clk};
      r_d_meta <= ps2_data;
      r_d_sync <= r_d_meta;

      if ((r_state == c_st_idle) && wr) begin
        r_sh <= {1'b1, ~^din, din};
        r_n  <= 4'd0;
      end else if ((r_state == c_st_bits) && w_fall && !w_timeout) begin
        r_sh <= {1'b0, r_sh[9:1]};
        r_n  <= r_n + 4'd1;
      end

      if ((w_state_next != r_state) || w_edge_live) begin
        r_timer <= 20'd0;
      end else if (r_timer != c_timer_max) begin
        r_timer <= r_timer + 20'd1;
      end

      r_clk_oe  <= w_clk_oe_next;
      r_data_oe <= w_data_oe_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_error   <= w_fail;
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Purpose  : Directed self-checking bench for ps2_tx with a PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

  localparam int c_freq     = 1000;
  localparam int c_inhibit  = c_freq / 10;
  localparam int c_setup    = c_freq / 200;
  localparam int c_start_to = c_freq * 15;
  localparam int c_bit_to   = c_freq * 2;
  localparam int c_half     = 40;   // 12.5 KHz device clock at 1 MHz

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_pin;
  logic       ps2_data_pin;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       error;

  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  logic [9:0] seen;
  int         hold_len;
  int         data_lead;
  logic       data_low_at_release;

  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(
    .FREQ(c_freq)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk_pin),
    .ps2_data   (ps2_data_pin),
    .din        (din),
    .wr         (wr),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_wr(input logic [7:0] b);
    @(negedge clk);
    din = b;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  // Device: waits for the host request, then clocks n_edges bits,
  // sampling the data line late in each clock-low phase.
  task automatic device(input int n_edges, input bit ack, output bit ok);
    int t;
    ok = 1'b0;
    hold_len = 0;
    data_lead = -1;
    data_low_at_release = 1'b0;
    t = 0;
    while (!ps2_clk_oe && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!ps2_clk_oe) return;
    while (ps2_clk_oe && t < 2000) begin
      if (ps2_data_oe && data_lead < 0) data_lead = hold_len;
      data_low_at_release = !ps2_data_pin;
      hold_len++;
      @(negedge clk);
      t++;
    end
    if (ps2_clk_oe) return;
    ok = 1'b1;
    cyc(c_half);
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && ack) begin
        dev_data_low = 1'b1;
        cyc(10);
      end
      dev_clk_low = 1'b1;
      cyc(c_half);
      if (i <= 10) seen[i-1] = ps2_data_pin;
      dev_clk_low = 1'b0;
      cyc(c_half);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int t;
    t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = !busy;
    cyc(2);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit ok2;
    int d0;
    int e0;
    int cnt;

    // Reset state
    cyc(3);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    cyc(3);

    // 0xF4 with ack, plus wr held across the DONE cycle
    d0 = done_cnt; e0 = err_cnt;
    seen = '0;
    send_wr(8'hF4);
    check("f4_busy_cycle1", busy, 1);
    check("f4_clk_oe_cycle1", ps2_clk_oe, 1);
    device(11, 1'b1, ok);
    check("f4_handshake", ok, 1);
    din = 8'h55;
    wr  = 1'b1;
    cnt = 0;
    while (!done && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("f4_done_seen", done, 1);
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    check("wr_in_done_ignored", busy, 0);
    cyc(2);
    check("f4_bits", seen, 10'h2F4);
    check("f4_done_count", done_cnt - d0, 1);
    check("f4_error_count", err_cnt - e0, 0);

    // 0xED: request timing and odd parity 1
    d0 = done_cnt; e0 = err_cnt;
    seen = '0;
    send_wr(8'hED);
    device(11, 1'b1, ok);
    check("ed_handshake", ok, 1);
    wait_idle(500, ok2);
    check("ed_idle", ok2, 1);
    check("ed_bits", seen, 10'h3ED);
    check("ed_parity", seen[8], 1);
    check("ed_clk_hold", hold_len, c_inhibit + c_setup);
    check("ed_data_lead", data_lead, c_inhibit);
    check("ed_data_low_before_release", data_low_at_release, 1);
    check("ed_done_count", done_cnt - d0, 1);

    // Device never clocks: start timeout
    d0 = done_cnt; e0 = err_cnt;
    send_wr(8'h12);
    cnt = 0;
    while (ps2_clk_oe && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (!error && cnt < c_start_to + 100) begin
      @(negedge clk);
      cnt++;
    end
    check("start_to_window", (cnt >= c_start_to + 1) && (cnt <= c_start_to + 6), 1);
    check("start_to_clk_oe", ps2_clk_oe, 0);
    check("start_to_data_oe", ps2_data_oe, 0);
    check("start_to_no_done", done, 0);
    cyc(3);
    check("start_to_err_count", err_cnt - e0, 1);

    // Device stops after edge 5: bit timeout
    d0 = done_cnt; e0 = err_cnt;
    send_wr(8'h34);
    device(5, 1'b0, ok);
    check("bit_to_handshake", ok, 1);
    cnt = c_half;
    while (!error && cnt < c_bit_to + 100) begin
      @(negedge clk);
      cnt++;
    end
    check("bit_to_window", (cnt >= c_bit_to) && (cnt <= c_bit_to + 8), 1);
    check("bit_to_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    check("bit_to_busy_after", busy, 0);
    cyc(2);
    check("bit_to_err_count", err_cnt - e0, 1);
    check("bit_to_done_count", done_cnt - d0, 0);

    // Missing ack
    d0 = done_cnt; e0 = err_cnt;
    send_wr(8'hF4);
    device(11, 1'b0, ok);
    wait_idle(500, ok2);
    check("noack_idle", ok2, 1);
`ifdef PS2_TX_ACK_CHECK_EN
    check("noack_err_count", err_cnt - e0, 1);
    check("noack_done_count", done_cnt - d0, 0);
`else
    check("noack_err_count", err_cnt - e0, 0);
    check("noack_done_count", done_cnt - d0, 1);
`endif

    // Second wr mid-transfer is ignored
    d0 = done_cnt; e0 = err_cnt;
    seen = '0;
    send_wr(8'hF4);
    fork
      device(11, 1'b1, ok);
      begin
        cyc(400);
        din = 8'hAA;
        wr  = 1'b1;
        cyc(1);
        wr  = 1'b0;
      end
    join
    wait_idle(500, ok2);
    check("midwr_bits", seen, 10'h2F4);
    check("midwr_done_count", done_cnt - d0, 1);

    // Reset at edge 4 releases both lines, no pulses
    d0 = done_cnt; e0 = err_cnt;
    send_wr(8'hF4);
    device(3, 1'b0, ok);
    dev_clk_low = 1'b1;
    cyc(10);
    check("rstmid_data_oe_before", ps2_data_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_clk_oe", ps2_clk_oe, 0);
    check("rstmid_data_oe", ps2_data_oe, 0);
    check("rstmid_busy", busy, 0);
    cyc(3);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    cyc(100);
    check("rstmid_done_count", done_cnt - d0, 0);
    check("rstmid_err_count", err_cnt - e0, 0);

    check("done_error_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
